aes_mcol_seq: RTL and testbench

Iterative MixColumns sequencer for the AES round datapath. It accepts a full `4*Nb`-byte state over a valid/ready handshake and pushes the columns one per cycle through a single shared column mixer. It holds the transformed state until downstream accepts it. It sits between ShiftRows and AddRoundKey and trades latency for one column's worth of GF(2^8) logic instead of `Nb`.

---
 rtl/aes_mcol_seq_if.sv | 44 ++++
 rtl/aes_mcol_seq.sv | 139 +++++++++++++
 tb/tb_aes_mcol_seq.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_mcol_seq_if.sv
// Handshake bundle for aes_mcol_seq: input state stream and result stream.
// Optional in_inv exists only when AES_MCOL_INV_EN is defined.
interface aes_mcol_seq_if #(
  parameter int unsigned Nb = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*Nb-1:0][7:0]  in_state;
  logic                  in_bypass;
`ifdef AES_MCOL_INV_EN
  logic                  in_inv;
`endif
  logic                  out_valid;
  logic                  out_ready;
  logic [4*Nb-1:0][7:0]  out_state;

  // Upstream/downstream side (drives states in, accepts results)
  modport master (
    output in_valid,
    output in_state,
    output in_bypass,
`ifdef AES_MCOL_INV_EN
    output in_inv,
`endif
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_state
  );

  // Sequencer side
  modport slave (
    input  in_valid,
    input  in_state,
    input  in_bypass,
`ifdef AES_MCOL_INV_EN
    input  in_inv,
`endif
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_state
  );
endinterface

// File: rtl/aes_mcol_seq.sv
// Iterative AES MixColumns: one shared column mixer, one column per cycle.
// Define AES_MCOL_INV_EN to add the in_inv port and InvMixColumns support.
module aes_mcol_seq #(
  parameter int unsigned Nb = 4
) (
  input  logic         clock,
  input  logic         reset,
  aes_mcol_seq_if.slave bus
);
  localparam int unsigned COL_W = (Nb > 1) ? $clog2(Nb) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef logic [3:0][7:0] col_t;

  state_t                 state;
  state_t                 state_nx;
  logic [COL_W-1:0]       col;
  logic [Nb-1:0][3:0][7:0] work;
  logic [Nb-1:0][3:0][7:0] result;
  logic                   accept;
  logic                   last_col;
  col_t                   cur;
  col_t                   mixed;
`ifdef AES_MCOL_INV_EN
  logic                   mode_inv;
`endif

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic col_t mix_fwd(input col_t a);
    col_t o;
    for (int r = 0; r < 4; r++) begin
      o[2'(r)] = xt(a[2'(r)])
               ^ (xt(a[2'(r + 1)]) ^ a[2'(r + 1)])
               ^ a[2'(r + 2)]
               ^ a[2'(r + 3)];
    end
    return o;
  endfunction

`ifdef AES_MCOL_INV_EN
  // Multiplies by 0e/0b/0d/09 share the x2/x4/x8 chain of each byte
  function automatic logic [7:0] mul_e(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
  endfunction
  function automatic logic [7:0] mul_b(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(b) ^ b;
  endfunction
  function automatic logic [7:0] mul_d(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
  endfunction
  function automatic logic [7:0] mul_9(input logic [7:0] b);
    return xt(xt(xt(b))) ^ b;
  endfunction

  function automatic col_t mix_inv(input col_t a);
    col_t o;
    for (int r = 0; r < 4; r++) begin
      o[2'(r)] = mul_e(a[2'(r)])
               ^ mul_b(a[2'(r + 1)])
               ^ mul_d(a[2'(r + 2)])
               ^ mul_9(a[2'(r + 3)]);
    end
    return o;
  endfunction
`endif

  assign cur      = work[col];
  assign last_col = (col == COL_W'(Nb - 1));
  assign accept   = bus.in_valid && bus.in_ready;

`ifdef AES_MCOL_INV_EN
  assign mixed = mode_inv ? mix_inv(cur) : mix_fwd(cur);
`else
  assign mixed = mix_fwd(cur);
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and handshake outputs
  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = !reset;
        if (bus.in_valid && !reset) state_nx = bus.in_bypass ? DONE : BUSY;
      end
      BUSY: begin
        if (last_col) state_nx = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Work/result buffers and column counter
  always_ff @(posedge clock) begin
    if (reset) begin
      col    <= '0;
      work   <= '0;
      result <= '0;
`ifdef AES_MCOL_INV_EN
      mode_inv <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            work <= bus.in_state;
            col  <= '0;
`ifdef AES_MCOL_INV_EN
            mode_inv <= bus.in_inv;
`endif
            if (bus.in_bypass) result <= bus.in_state;
          end
        end
        BUSY: begin
          result[col] <= mixed;
          if (!last_col) col <= col + COL_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.out_state = result;

endmodule

// File: tb/tb_aes_mcol_seq.sv
// Directed self-checking bench for aes_mcol_seq (Nb=4) using known MixColumns
// column vectors; inverse checks run when AES_MCOL_INV_EN is defined.
module tb_aes_mcol_seq;
  typedef logic [15:0][7:0] st_t;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  aes_mcol_seq_if #(.Nb(4)) bus ();

  aes_mcol_seq #(.Nb(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] col_in  [6];
  logic [31:0] col_out [6];

  function automatic st_t mk(input logic [31:0] c0, input logic [31:0] c1,
                             input logic [31:0] c2, input logic [31:0] c3);
    st_t s;
    logic [3:0][31:0] c;
    c = {c3, c2, c1, c0};
    for (int j = 0; j < 4; j++)
      for (int r = 0; r < 4; r++)
        s[4'(4*j + r)] = c[2'(j)][8*(3-r) +: 8];
    return s;
  endfunction

  task automatic send(input st_t s, input logic byp, input logic inv);
    @(negedge clock);
    bus.in_valid  = 1'b1;
    bus.in_state  = s;
    bus.in_bypass = byp;
`ifdef AES_MCOL_INV_EN
    bus.in_inv    = inv;
`else
    if (inv) $display("note: inverse request ignored in forward-only build");
`endif
    for (int k = 0; k < 50 && !bus.in_ready; k++) @(negedge clock);
    if (!bus.in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: in_ready=%0b required 1", bus.in_ready);
    end
    @(posedge clock);
    #1;
    bus.in_valid  = 1'b0;
    bus.in_bypass = 1'b0;
  endtask

  task automatic wait_out();
    for (int k = 0; k < 50 && !bus.out_valid; k++) begin
      @(posedge clock);
      #1;
    end
    if (!bus.out_valid) begin
      n_checks++; n_fail++;
      $display("FAIL out_timeout: out_valid=%0b required 1", bus.out_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_bypass = 1'b0; bus.out_ready = 1'b0;
    bus.in_state = '0;
`ifdef AES_MCOL_INV_EN
    bus.in_inv = 1'b0;
`endif
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %0b want 0", bus.in_ready); end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0b want 0", bus.out_valid); end
    n_checks++;
    if (bus.out_state !== st_t'(0)) begin n_fail++; $display("FAIL rst_out_state: got %h want 0", bus.out_state); end
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %0b want 1", bus.in_ready); end
  endtask

  task automatic test_mix_latency();
    st_t exp;
    exp = mk(col_out[0], col_out[1], col_out[2], col_out[3]);
    bus.out_ready = 1'b1;
    send(mk(col_in[0], col_in[1], col_in[2], col_in[3]), 1'b0, 1'b0);
    // Mode changes after acceptance must not matter
    bus.in_bypass = 1'b1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_e0: out_valid=%0b want 0", bus.out_valid); end
    for (int i = 1; i <= 4; i++) begin
      @(posedge clock);
      #1;
      n_checks++;
      if (bus.out_valid !== (i == 4)) begin
        n_fail++; $display("FAIL lat_e%0d: out_valid=%0b want %0b", i, bus.out_valid, (i == 4));
      end
    end
    n_checks++;
    if (bus.out_state !== exp) begin n_fail++; $display("FAIL mix_fwd1: got %h want %h", bus.out_state, exp); end
    bus.in_bypass = 1'b0;
    @(posedge clock);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL out_hs: out_valid=%0b in_ready=%0b want 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_backpressure();
    st_t exp;
    exp = mk(col_out[4], col_out[4], col_out[5], col_out[5]);
    bus.out_ready = 1'b0;
    send(mk(col_in[4], col_in[4], col_in[5], col_in[5]), 1'b0, 1'b0);
    repeat (4) @(posedge clock);
    #1;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.in_state = mk(col_in[0], col_in[0], col_in[0], col_in[0]);
      @(posedge clock);
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_state !== exp) begin
        n_fail++;
        $display("FAIL hold_%0d: valid=%0b ready=%0b state=%h want 1/0/%h",
                 i, bus.out_valid, bus.in_ready, bus.out_state, exp);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: out_valid=%0b want 0", bus.out_valid); end
    repeat (6) @(posedge clock);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_capture: out_valid=%0b want 0", bus.out_valid); end
  endtask

  task automatic test_bypass();
    st_t s;
    for (int i = 0; i < 16; i++) s[4'(i)] = 8'($urandom);
    bus.out_ready = 1'b0;
    send(s, 1'b1, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_state !== s) begin
      n_fail++; $display("FAIL bypass: valid=%0b state=%h want 1/%h", bus.out_valid, bus.out_state, s);
    end
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset_mid();
    logic seen;
    st_t  exp;
    exp = mk(col_out[0], col_out[1], col_out[2], col_out[3]);
    bus.out_ready = 1'b1;
    send(mk(col_in[1], col_in[0], col_in[4], col_in[5]), 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_state !== st_t'(0) || bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: valid=%0b state=%h ready=%0b want 0/0/0",
                         bus.out_valid, bus.out_state, bus.in_ready);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready: got %0b want 1", bus.in_ready); end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_reset_discard: out_valid seen=%0b want 0", seen); end
    bus.out_ready = 1'b0;
    send(mk(col_in[0], col_in[1], col_in[2], col_in[3]), 1'b0, 1'b0);
    wait_out();
    n_checks++;
    if (bus.out_state !== exp) begin n_fail++; $display("FAIL mid_reset_next: got %h want %h", bus.out_state, exp); end
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
  endtask

`ifdef AES_MCOL_INV_EN
  task automatic test_inverse();
    st_t s, fwd;
    bus.out_ready = 1'b0;
    send(mk(col_out[0], col_out[1], col_out[2], col_out[3]), 1'b0, 1'b1);
    wait_out();
    n_checks++;
    if (bus.out_state !== mk(col_in[0], col_in[1], col_in[2], col_in[3])) begin
      n_fail++; $display("FAIL inv_known: got %h want %h", bus.out_state,
                         mk(col_in[0], col_in[1], col_in[2], col_in[3]));
    end
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < 16; i++) s[4'(i)] = 8'($urandom);
    bus.out_ready = 1'b0;
    send(s, 1'b0, 1'b0);
    wait_out();
    fwd = bus.out_state;
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.out_ready = 1'b0;
    send(fwd, 1'b0, 1'b1);
    wait_out();
    n_checks++;
    if (bus.out_state !== s) begin n_fail++; $display("FAIL inv_roundtrip: got %h want %h", bus.out_state, s); end
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
  endtask
`endif

  task automatic test_back_to_back();
    st_t  sin [8];
    st_t  sexp[8];
    logic byp [8];
    int   nin, nout, last_acc;
    logic prev_byp, acc, hs;
    for (int k = 0; k < 8; k++) begin
      byp[k]  = (k == 2) || (k == 5);
      sin[k]  = mk(col_in[(k) % 6], col_in[(k+1) % 6], col_in[(k+2) % 6], col_in[(k+3) % 6]);
      sexp[k] = byp[k] ? sin[k]
              : mk(col_out[(k) % 6], col_out[(k+1) % 6], col_out[(k+2) % 6], col_out[(k+3) % 6]);
    end
    nin = 0; nout = 0; last_acc = -100; prev_byp = 1'b0;
    for (int cyc = 0; cyc < 2000 && nout < 8; cyc++) begin
      @(negedge clock);
      if (nin < 8) begin
        bus.in_valid = 1'b1; bus.in_state = sin[nin]; bus.in_bypass = byp[nin];
      end else begin
        bus.in_valid = 1'b0; bus.in_bypass = 1'b0;
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      acc = bus.in_valid && bus.in_ready;
      hs  = bus.out_valid && bus.out_ready;
      if (hs) begin
        n_checks++;
        if (bus.out_state !== sexp[nout]) begin
          n_fail++; $display("FAIL b2b_data_%0d: got %h want %h", nout, bus.out_state, sexp[nout]);
        end
        nout++;
      end
      if (acc) begin
        if (nin > 0) begin
          n_checks++;
          if ((cyc - last_acc) < (prev_byp ? 2 : 6)) begin
            n_fail++; $display("FAIL b2b_spacing_%0d: got %0d want >= %0d", nin, cyc - last_acc, prev_byp ? 2 : 6);
          end
        end
        last_acc = cyc; prev_byp = byp[nin]; nin++;
      end
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (nout != 8 || nin != 8) begin n_fail++; $display("FAIL b2b_count: in=%0d out=%0d want 8/8", nin, nout); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    col_in[0] = 32'hdb135345; col_out[0] = 32'h8e4da1bc;
    col_in[1] = 32'hf20a225c; col_out[1] = 32'h9fdc589d;
    col_in[2] = 32'h01010101; col_out[2] = 32'h01010101;
    col_in[3] = 32'hc6c6c6c6; col_out[3] = 32'hc6c6c6c6;
    col_in[4] = 32'hd4d4d4d5; col_out[4] = 32'hd5d5d7d6;
    col_in[5] = 32'h2d26314c; col_out[5] = 32'h4d7ebdf8;
    test_reset();
    test_mix_latency();
    test_backpressure();
    test_bypass();
    test_reset_mid();
`ifdef AES_MCOL_INV_EN
    test_inverse();
`endif
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
